// File: rtl/fault_test_sequencer.sv
// rtl/fault_test_sequencer.sv - exhaustive 3-bit stimulus sweep with golden/faulty response comparison
module fault_test_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  output logic       C,
  input  logic       F0_good,
  input  logic       F1_good,
  input  logic       F0_dut,
  input  logic       F1_dut,
  output logic       busy,
  output logic       done,
  output logic       fault_detected,
  output logic [7:0] fail_mask,
  output logic [3:0] fail_count,
  output logic [2:0] first_fail_vec,
  output logic       f0_fail_any,
  output logic       f1_fail_any
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Settle counter value on the last APPLY cycle of a vector.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] vec, vec_nxt;
  logic [3:0] settle, settle_nxt;
  logic       busy_nxt, done_nxt;
  logic       fault_detected_nxt;
  logic [7:0] fail_mask_nxt;
  logic [3:0] fail_count_nxt;
  logic [2:0] first_fail_vec_nxt;
  logic       f0_fail_any_nxt, f1_fail_any_nxt;

  logic       f0_diff, f1_diff, mismatch;

  // The applied vector is the registered vector counter itself, so A/B/C
  // change only on clock edges and read 7 while results are held in DONE.
  assign {A, B, C} = vec;

  assign f0_diff  = F0_good ^ F0_dut;
  assign f1_diff  = F1_good ^ F1_dut;
  assign mismatch = f0_diff | f1_diff;

  // State register and all registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      vec            <= 3'd0;
      settle         <= 4'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      fault_detected <= 1'b0;
      fail_mask      <= 8'h00;
      fail_count     <= 4'd0;
      first_fail_vec <= 3'd0;
      f0_fail_any    <= 1'b0;
      f1_fail_any    <= 1'b0;
    end else begin
      state          <= state_nxt;
      vec            <= vec_nxt;
      settle         <= settle_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      fault_detected <= fault_detected_nxt;
      fail_mask      <= fail_mask_nxt;
      fail_count     <= fail_count_nxt;
      first_fail_vec <= first_fail_vec_nxt;
      f0_fail_any    <= f0_fail_any_nxt;
      f1_fail_any    <= f1_fail_any_nxt;
    end
  end

  // Next-state and next-result logic; everything holds unless a state acts on it.
  always_comb begin
    state_nxt          = state;
    vec_nxt            = vec;
    settle_nxt         = settle;
    busy_nxt           = busy;
    done_nxt           = done;
    fault_detected_nxt = fault_detected;
    fail_mask_nxt      = fail_mask;
    fail_count_nxt     = fail_count;
    first_fail_vec_nxt = first_fail_vec;
    f0_fail_any_nxt    = f0_fail_any;
    f1_fail_any_nxt    = f1_fail_any;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt          = ST_APPLY;
          vec_nxt            = 3'd0;
          settle_nxt         = 4'd0;
          busy_nxt           = 1'b1;
          done_nxt           = 1'b0;
          fault_detected_nxt = 1'b0;
          fail_mask_nxt      = 8'h00;
          fail_count_nxt     = 4'd0;
          first_fail_vec_nxt = 3'd0;
          f0_fail_any_nxt    = 1'b0;
          f1_fail_any_nxt    = 1'b0;
        end
      end

      ST_APPLY: begin
        settle_nxt = settle + 4'd1;
        if (settle == SETTLE_LAST) begin
          state_nxt = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (mismatch) begin
          fail_mask_nxt   = fail_mask | (8'h01 << vec);
          fail_count_nxt  = fail_count + 4'd1;
          f0_fail_any_nxt = f0_fail_any | f0_diff;
          f1_fail_any_nxt = f1_fail_any | f1_diff;
          if (!fault_detected) begin
            fault_detected_nxt = 1'b1;
            first_fail_vec_nxt = vec;
          end
        end
        if (vec == 3'd7) begin
          state_nxt = ST_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          state_nxt  = ST_APPLY;
          vec_nxt    = vec + 3'd1;
          settle_nxt = 4'd0;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fault_test_sequencer.sv
// tb/tb_fault_test_sequencer.sv - self-checking bench for fault_test_sequencer
module tb_fault_test_sequencer;

  localparam int SC = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       a, b, c;
  logic       f0_good, f1_good, f0_dut, f1_dut;
  logic       busy, done, fault_detected;
  logic [7:0] fail_mask;
  logic [3:0] fail_count;
  logic [2:0] first_fail_vec;
  logic       f0_fail_any, f1_fail_any;
  logic [7:0] tt0, tt1;

  logic       start_aux;
  logic       a1, b1, c1, busy1, done1, fd1, f0a1, f1a1;
  logic [7:0] fm1;
  logic [3:0] fc1;
  logic [2:0] ffv1;
  logic       a15, b15, c15, busy15, done15, fd15, f0a15, f1a15;
  logic [7:0] fm15;
  logic [3:0] fc15;
  logic [2:0] ffv15;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_mask;
  int         exp_cnt;
  int         exp_first;
  logic       exp_f0, exp_f1, exp_fd;
  logic [7:0] g0, g1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden full adder and a table-driven faulty circuit.
  assign f0_good = a ^ b ^ c;
  assign f1_good = (a & b) | (c & (a ^ b));
  assign f0_dut  = tt0[{a, b, c}];
  assign f1_dut  = tt1[{a, b, c}];

  fault_test_sequencer #(.SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .C(c),
    .F0_good(f0_good), .F1_good(f1_good), .F0_dut(f0_dut), .F1_dut(f1_dut),
    .busy(busy), .done(done), .fault_detected(fault_detected),
    .fail_mask(fail_mask), .fail_count(fail_count), .first_fail_vec(first_fail_vec),
    .f0_fail_any(f0_fail_any), .f1_fail_any(f1_fail_any)
  );

  fault_test_sequencer #(.SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_aux), .A(a1), .B(b1), .C(c1),
    .F0_good(a1 ^ b1 ^ c1), .F1_good((a1 & b1) | (c1 & (a1 ^ b1))),
    .F0_dut(a1 ^ b1 ^ c1), .F1_dut((a1 & b1) | (c1 & (a1 ^ b1))),
    .busy(busy1), .done(done1), .fault_detected(fd1),
    .fail_mask(fm1), .fail_count(fc1), .first_fail_vec(ffv1),
    .f0_fail_any(f0a1), .f1_fail_any(f1a1)
  );

  fault_test_sequencer #(.SETTLE_CYCLES(15)) dut_s15 (
    .clk(clk), .rst_n(rst_n), .start(start_aux), .A(a15), .B(b15), .C(c15),
    .F0_good(a15 ^ b15 ^ c15), .F1_good((a15 & b15) | (c15 & (a15 ^ b15))),
    .F0_dut(a15 ^ b15 ^ c15), .F1_dut((a15 & b15) | (c15 & (a15 ^ b15))),
    .busy(busy15), .done(done15), .fault_detected(fd15),
    .fail_mask(fm15), .fail_count(fc15), .first_fail_vec(ffv15),
    .f0_fail_any(f0a15), .f1_fail_any(f1a15)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Truth tables of the golden adder from the count of ones in the vector.
  task automatic build_golden();
    for (int v = 0; v < 8; v++) begin
      int ones;
      ones  = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
      g0[v] = (ones % 2) == 1;
      g1[v] = ones >= 2;
    end
  endtask

  // Expected report: per-vector differences between golden and faulty tables.
  task automatic model(input logic [7:0] t0, input logic [7:0] t1);
    exp_mask  = 8'h00;
    exp_cnt   = 0;
    exp_first = -1;
    exp_f0    = 1'b0;
    exp_f1    = 1'b0;
    for (int v = 0; v < 8; v++) begin
      logic d0, d1;
      d0 = t0[v] != g0[v];
      d1 = t1[v] != g1[v];
      if (d0 || d1) begin
        exp_mask[v] = 1'b1;
        exp_cnt++;
        if (exp_first < 0) exp_first = v;
      end
      exp_f0 = exp_f0 | d0;
      exp_f1 = exp_f1 | d1;
    end
    exp_fd = exp_cnt > 0;
    if (exp_first < 0) exp_first = 0;
  endtask

  task automatic check_results(input string tag);
    check({tag, ".done"}, done, 1);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".fault_detected"}, fault_detected, exp_fd);
    check({tag, ".fail_mask"}, fail_mask, exp_mask);
    check({tag, ".fail_count"}, fail_count, exp_cnt);
    check({tag, ".first_fail_vec"}, first_fail_vec, exp_first);
    check({tag, ".f0_fail_any"}, f0_fail_any, exp_f0);
    check({tag, ".f1_fail_any"}, f1_fail_any, exp_f1);
    check({tag, ".abc_hold"}, {a, b, c}, 7);
  endtask

  // Full sweep from IDLE/DONE; start held for 'hold' edges; checks timing, order and results.
  task automatic do_sweep(input logic [7:0] t0, input logic [7:0] t1, input int hold, input string tag);
    int  busy_cnt;
    int  done_at;
    bit  seq_ok;
    tt0 = t0;
    tt1 = t1;
    model(t0, t1);
    @(negedge clk);
    start    = 1'b1;
    busy_cnt = 0;
    done_at  = -1;
    seq_ok   = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k + 1 >= hold) start = 1'b0;
      if (busy) begin
        if ({a, b, c} !== 3'(busy_cnt / (SC + 1))) seq_ok = 1'b0;
        busy_cnt++;
      end
      if (done) begin
        done_at = k;
        break;
      end
    end
    start = 1'b0;
    check({tag, ".done_edge"}, done_at, 8 * (SC + 1));
    check({tag, ".busy_cycles"}, busy_cnt, 8 * (SC + 1));
    check({tag, ".vec_order"}, seq_ok, 1);
    check_results(tag);
  endtask

  initial begin
    int  d1_at, d15_at, n1, n15, k4;
    bit  ok1, ok15;
    logic [7:0] r0, r1, st1;

    build_golden();
    rst_n     = 1'b0;
    start     = 1'b0;
    start_aux = 1'b0;
    tt0       = g0;
    tt1       = g1;
    repeat (3) @(negedge clk);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.abc", {a, b, c}, 0);
    check("reset.fault_detected", fault_detected, 0);
    check("reset.fail_mask", fail_mask, 0);
    check("reset.fail_count", fail_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases from the lab plan.
    for (int v = 0; v < 8; v++) st1[v] = (((v >> 2) & 1) & ((v >> 1) & 1)) | (v & 1);
    do_sweep(g0, g1, 1, "identical");
    do_sweep(g0, st1, 1, "carry_sa1");
    do_sweep(~g0, g1, 1, "f0_inverted");
    do_sweep(~g0, ~g1, 1, "both_inverted");

    // Start held high for most of the sweep must not restart it.
    do_sweep(g0 ^ 8'h90, g1 ^ 8'h09, 18, "start_held");

    // Restart from DONE clears prior results the cycle after start.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart.done", done, 0);
    check("restart.busy", busy, 1);
    check("restart.fail_mask", fail_mask, 0);
    check("restart.fail_count", fail_count, 0);
    check("restart.fault_detected", fault_detected, 0);
    check("restart.abc", {a, b, c}, 0);
    k4 = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin
        k4 = k;
        break;
      end
    end
    check("restart.done_edge", k4, 8 * (SC + 1) - 1);
    check_results("restart");

    // Reset during vector 4 of an all-failing sweep.
    tt0 = ~g0;
    tt1 = g1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k4 = -1;
    for (int k = 0; k < 300; k++) begin
      if ({a, b, c} === 3'd4) begin
        k4 = k;
        break;
      end
      @(negedge clk);
    end
    check("midreset.reached_vec4", k4 >= 0, 1);
    check("midreset.mask_before", fail_mask, 8'h0F);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset.busy", busy, 0);
    check("midreset.done", done, 0);
    check("midreset.abc", {a, b, c}, 0);
    check("midreset.fail_mask", fail_mask, 0);
    check("midreset.fail_count", fail_count, 0);
    check("midreset.first_fail_vec", first_fail_vec, 0);
    check("midreset.fault_detected", fault_detected, 0);
    check("midreset.f0_fail_any", f0_fail_any, 0);
    repeat (3) @(negedge clk);
    check("midreset.idle_busy", busy, 0);
    check("midreset.idle_abc", {a, b, c}, 0);
    do_sweep(~g0, g1, 1, "after_reset");

    // Randomised faulty circuits checked against the table model.
    for (int i = 0; i < 8; i++) begin
      r0 = 8'($urandom & $urandom);
      r1 = 8'($urandom & $urandom);
      if (i == 0) r0 = 8'h80;
      do_sweep(g0 ^ r0, g1 ^ r1, $urandom_range(1, 15), $sformatf("rand%0d", i));
    end

    // SETTLE_CYCLES = 1 and 15 instances: sweep length and vector order.
    @(negedge clk);
    start_aux = 1'b1;
    d1_at  = -1;
    d15_at = -1;
    n1     = 0;
    n15    = 0;
    ok1    = 1'b1;
    ok15   = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start_aux = 1'b0;
      if (busy1) begin
        if ({a1, b1, c1} !== 3'(n1 / 2)) ok1 = 1'b0;
        n1++;
      end
      if (busy15) begin
        if ({a15, b15, c15} !== 3'(n15 / 16)) ok15 = 1'b0;
        n15++;
      end
      if (done1 && d1_at < 0) d1_at = k;
      if (done15 && d15_at < 0) d15_at = k;
      if (d1_at >= 0 && d15_at >= 0) break;
    end
    check("s1.done_edge", d1_at, 16);
    check("s1.busy_cycles", n1, 16);
    check("s1.vec_order", ok1, 1);
    check("s1.fault_detected", fd1, 0);
    check("s1.fail_mask", fm1, 0);
    check("s15.done_edge", d15_at, 128);
    check("s15.busy_cycles", n15, 128);
    check("s15.vec_order", ok15, 1);
    check("s15.fault_detected", fd15, 0);
    check("s15.fail_count", fc15, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
